// File: rtl/conv_operand_server_if.sv
// Host write port, burst request channel and streamed data channel of the
// convolution operand server. Signal directions are named from the server's side.
interface conv_operand_server_if #(
    parameter int DATA_W = 8,
    parameter int SRC_AW = 10,
    parameter int LEN_W  = 11
);
    logic              i_wr_en;
    logic              i_wr_sel;
    logic [SRC_AW-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;

    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_sel;
    logic [SRC_AW-1:0] i_req_addr;
    logic [LEN_W-1:0]  i_req_len;

    logic              o_data_valid;
    logic              i_data_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_data_last;
    logic              o_done;

    modport master (
        output i_wr_en, i_wr_sel, i_wr_addr, i_wr_data,
        output i_req_valid, i_req_sel, i_req_addr, i_req_len,
        input  o_req_ready,
        output i_data_ready,
        input  o_data_valid, o_data, o_data_last, o_done
    );

    modport slave (
        input  i_wr_en, i_wr_sel, i_wr_addr, i_wr_data,
        input  i_req_valid, i_req_sel, i_req_addr, i_req_len,
        output o_req_ready,
        input  i_data_ready,
        output o_data_valid, o_data, o_data_last, o_done
    );
endinterface

// File: rtl/conv_operand_server.sv
// Operand store (SRC feature map + 4x4 kernel) with a burst read responder that
// streams words over valid/ready with a registered output and no bubbles.
module conv_operand_server #(
    parameter int DATA_W = 8,
    parameter int SRC_AW = 10,
    parameter int KER_AW = 4,
    parameter int LEN_W  = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    conv_operand_server_if.slave    bus
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    logic [DATA_W-1:0] src_mem [2**SRC_AW];
    logic [DATA_W-1:0] ker_mem [2**KER_AW];

    state_t            state_q, state_d;
    logic              sel_q;
    logic [SRC_AW-1:0] addr_q;       // address of the next word to load
    logic [LEN_W-1:0]  remaining_q;  // words not yet transferred, incl. the one in o_data
    logic              valid_q, last_q, done_q;
    logic [DATA_W-1:0] data_q;

    logic              accept, zero_req, beat, final_beat, load_en;
    logic              load_sel;
    logic [SRC_AW-1:0] load_addr;
    logic [DATA_W-1:0] rd_word;

    // NOTE: storage has no reset; contents survive i_rst_n and only host writes change them.
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_en) begin
            if (bus.i_wr_sel) ker_mem[bus.i_wr_addr[KER_AW-1:0]] <= bus.i_wr_data;
            else              src_mem[bus.i_wr_addr]             <= bus.i_wr_data;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        accept     = 1'b0;
        zero_req   = 1'b0;
        beat       = 1'b0;
        final_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    if (bus.i_req_len != '0) begin
                        accept  = 1'b1;
                        state_d = STREAM;
                    end else begin
                        zero_req = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (valid_q && bus.i_data_ready) begin
                    beat = 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        final_beat = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Memory is read before this edge's host write lands, giving read-before-write.
        load_en   = accept | (beat & ~final_beat);
        load_sel  = accept ? bus.i_req_sel  : sel_q;
        load_addr = accept ? bus.i_req_addr : addr_q;
        rd_word   = load_sel ? ker_mem[load_addr[KER_AW-1:0]] : src_mem[load_addr];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= zero_req | final_beat;
            if (accept) begin
                sel_q       <= bus.i_req_sel;
                remaining_q <= bus.i_req_len;
                valid_q     <= 1'b1;
                last_q      <= (bus.i_req_len == LEN_W'(1));
            end else if (final_beat) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (beat) begin
                remaining_q <= remaining_q - LEN_W'(1);
                last_q      <= (remaining_q == LEN_W'(2));
            end
            if (load_en) begin
                data_q <= rd_word;
                addr_q <= load_addr + SRC_AW'(1);
            end
        end
    end

    assign bus.o_req_ready  = (state_q == IDLE);
    assign bus.o_data_valid = valid_q;
    assign bus.o_data_last  = last_q;
    assign bus.o_data       = data_q;
    assign bus.o_done       = done_q;

endmodule
